// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared widths, depths and the ALU operation encoding used by
//                the execution datapath and by the control-unit FSM that
//                drives Alu_s0.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DATA_W      = 16;   // datapath word width
    localparam int RF_DEPTH    = 16;   // register file entries
    localparam int RF_ADDR_W   = 4;    // register file address width
    localparam int DMEM_DEPTH  = 256;  // data memory words
    localparam int DMEM_ADDR_W = 8;    // data memory address width

    // ALU operation select, as encoded on Alu_s0
    typedef enum logic [2:0] {
        ALU_ZERO  = 3'd0,   // Y = 0
        ALU_ADD   = 3'd1,   // Y = A + B
        ALU_SUB   = 3'd2,   // Y = A - B
        ALU_PASSA = 3'd3,   // Y = A
        ALU_XOR   = 3'd4,   // Y = A ^ B
        ALU_OR    = 3'd5,   // Y = A | B
        ALU_AND   = 3'd6,   // Y = A & B
        ALU_INC   = 3'd7    // Y = A + 1
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/datapath_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 16 x 16-bit register file with two combinational read ports
//                and one synchronous write port. R0 is an ordinary register.
//                A write and a read of the same register in one cycle returns
//                the pre-edge contents; the new value appears next cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   1   rising-edge clock
//    rst      in   1   synchronous active-high reset, clears all registers
//    wr_en    in   1   write enable
//    wr_addr  in   4   write address
//    wr_data  in  16   write data
//    ra_addr  in   4   read port A address
//    rb_addr  in   4   read port B address
//    ra_data  out 16   read port A data
//    rb_data  out 16   read port B data
// ============================================================================
module register_file
    import datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [RF_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [RF_ADDR_W-1:0] ra_addr,
    input  logic [RF_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]    ra_data,
    output logic [DATA_W-1:0]    rb_data
);

    logic [DATA_W-1:0] r_regs [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // No write bypass: reads always see the registered contents.
    assign ra_data = r_regs[ra_addr];
    assign rb_data = r_regs[rb_addr];

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
//  Module      : datapath
//  Description : Execution datapath of the 16-bit processor. Executes the
//                control word on its inputs every cycle: register file, ALU,
//                256 x 16 data memory with registered read, and write-back
//                mux. Register and memory writes commit on the rising edge.
//  Revision    : 1.0 - initial release
//
//  Build option
//    DATAPATH_FLAGS_EN  when defined, Z_Flag/C_Flag are registered whenever
//                       an ALU result is written back; otherwise both are 0.
//
//  Ports
//    Clk         in   1   rising-edge clock
//    Rst         in   1   synchronous active-high reset
//    D_Addr      in   8   data memory address
//    D_Wr        in   1   data memory write enable (writes Ra_Data)
//    RF_s        in   1   write-back select: 1 = memory read data, 0 = ALU
//    RF_W_en     in   1   register file write enable
//    RF_W_Addr   in   4   register file write address
//    RF_Ra_Addr  in   4   read port A address
//    RF_Rb_Addr  in   4   read port B address
//    Alu_s0      in   3   ALU operation select (alu_op_t)
//    Ra_Data     out 16   register file port A
//    Rb_Data     out 16   register file port B
//    ALU_Out     out 16   combinational ALU result
//    Z_Flag      out  1   zero flag
//    C_Flag      out  1   carry / borrow flag
// ============================================================================
module datapath
    import datapath_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [DMEM_ADDR_W-1:0] D_Addr,
    input  logic                   D_Wr,
    input  logic                   RF_s,
    input  logic                   RF_W_en,
    input  logic [RF_ADDR_W-1:0]   RF_W_Addr,
    input  logic [RF_ADDR_W-1:0]   RF_Ra_Addr,
    input  logic [RF_ADDR_W-1:0]   RF_Rb_Addr,
    input  logic [2:0]             Alu_s0,
    output logic [DATA_W-1:0]      Ra_Data,
    output logic [DATA_W-1:0]      Rb_Data,
    output logic [DATA_W-1:0]      ALU_Out,
    output logic                   Z_Flag,
    output logic                   C_Flag
);

    alu_op_t           w_op;
    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] r_dmem_rdata;
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    assign w_op = alu_op_t'(Alu_s0);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    register_file u_register_file (
        .clk     (Clk),
        .rst     (Rst),
        .wr_en   (RF_W_en),
        .wr_addr (RF_W_Addr),
        .wr_data (w_wb_data),
        .ra_addr (RF_Ra_Addr),
        .rb_addr (RF_Rb_Addr),
        .ra_data (Ra_Data),
        .rb_data (Rb_Data)
    );

    // ------------------------------------------------------------------
    // ALU, all results modulo 2^16
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_y = '0;
        case (w_op)
            ALU_ZERO:  w_alu_y = '0;
            ALU_ADD:   w_alu_y = Ra_Data + Rb_Data;
            ALU_SUB:   w_alu_y = Ra_Data - Rb_Data;
            ALU_PASSA: w_alu_y = Ra_Data;
            ALU_XOR:   w_alu_y = Ra_Data ^ Rb_Data;
            ALU_OR:    w_alu_y = Ra_Data | Rb_Data;
            ALU_AND:   w_alu_y = Ra_Data & Rb_Data;
            ALU_INC:   w_alu_y = Ra_Data + DATA_W'(1);
            default:   w_alu_y = '0;
        endcase
    end

    assign ALU_Out = w_alu_y;

    // ------------------------------------------------------------------
    // Data memory. The array has no reset so contents survive Rst; the
    // write is gated by Rst so a reset edge never corrupts memory. The
    // read register samples the old word, giving read-before-write.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst && D_Wr) begin
            r_dmem[D_Addr] <= Ra_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_dmem_rdata <= '0;
        end else begin
            r_dmem_rdata <= r_dmem[D_Addr];
        end
    end

    // Write-back mux
    assign w_wb_data = RF_s ? r_dmem_rdata : w_alu_y;

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
`ifdef DATAPATH_FLAGS_EN
    logic w_c_next;
    logic r_z_flag;
    logic r_c_flag;

    // Carry derived from the truncated result: an add wrapped iff the
    // sum is below an operand; A+1 wraps only from all-ones.
    always_comb begin
        w_c_next = 1'b0;
        case (w_op)
            ALU_ADD: w_c_next = (w_alu_y < Ra_Data);
            ALU_SUB: w_c_next = (Ra_Data < Rb_Data);
            ALU_INC: w_c_next = (Ra_Data == {DATA_W{1'b1}});
            default: w_c_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_z_flag <= 1'b0;
            r_c_flag <= 1'b0;
        end else if (RF_W_en && !RF_s) begin
            r_z_flag <= (w_alu_y == '0);
            r_c_flag <= w_c_next;
        end
    end

    assign Z_Flag = r_z_flag;
    assign C_Flag = r_c_flag;
`else
    assign Z_Flag = 1'b0;
    assign C_Flag = 1'b0;
`endif

endmodule
`default_nettype wire
